fu1_writeback: RTL and testbench

Writeback buffer between FU1 (complex ALU) and the shared register-file write/bypass port. It accepts FU1 result packets every cycle and holds them in a small in-order buffer until the write port grants. It applies branch resolution to every held entry: entries younger than a mispredicted branch are squashed, and resolved-correct checkpoints are cleared from their masks. Its outputs drive the physical register file write, the bypass network and active-list completion.

---
 rtl/fu1_writeback_pkg.sv | 59 +++++
 rtl/fu1_writeback_wb_entry_filter.sv | 25 ++
 rtl/fu1_writeback.sv | 130 +++++++++++++
 tb/tb_fu1_writeback.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fu1_writeback_pkg.sv
// Shared FU result packet layout and writeback payload type.
// Field offsets are reused by every FU and writeback block.
package fu1_writeback_pkg;

  localparam int CHECKPOINTS         = 4;
  localparam int CHECKPOINTS_LOG     = 2;
  localparam int EXECUTION_FLAGS     = 4;
  localparam int SIZE_PHYSICAL_LOG   = 7;
  localparam int SIZE_ACTIVELIST_LOG = 6;
  localparam int SIZE_DATA           = 32;
  localparam int SIZE_ISSUEQ_LOG     = 5;
  localparam int SIZE_LSQ_LOG        = 5;
  localparam int SIZE_CTI_LOG        = 4;
  localparam int SIZE_PC             = 32;

  // Packet fields packed LSB upward, brDir at bit 0, branchMask on top.
  localparam int FU_PKT_BRDIR_LSB   = 0;
  localparam int FU_PKT_BRDIR_MSB   = 0;
  localparam int FU_PKT_TARADDR_LSB = FU_PKT_BRDIR_MSB + 1;
  localparam int FU_PKT_TARADDR_MSB = FU_PKT_TARADDR_LSB + SIZE_PC - 1;
  localparam int FU_PKT_CTIQ_LSB    = FU_PKT_TARADDR_MSB + 1;
  localparam int FU_PKT_CTIQ_MSB    = FU_PKT_CTIQ_LSB + SIZE_CTI_LOG - 1;
  localparam int FU_PKT_SMTID_LSB   = FU_PKT_CTIQ_MSB + 1;
  localparam int FU_PKT_SMTID_MSB   = FU_PKT_SMTID_LSB + CHECKPOINTS_LOG - 1;
  localparam int FU_PKT_LSQID_LSB   = FU_PKT_SMTID_MSB + 1;
  localparam int FU_PKT_LSQID_MSB   = FU_PKT_LSQID_LSB + SIZE_LSQ_LOG - 1;
  localparam int FU_PKT_IQ_LSB      = FU_PKT_LSQID_MSB + 1;
  localparam int FU_PKT_IQ_MSB      = FU_PKT_IQ_LSB + SIZE_ISSUEQ_LOG - 1;
  localparam int FU_PKT_RESULT_LSB  = FU_PKT_IQ_MSB + 1;
  localparam int FU_PKT_RESULT_MSB  = FU_PKT_RESULT_LSB + SIZE_DATA - 1;
  localparam int FU_PKT_ALID_LSB    = FU_PKT_RESULT_MSB + 1;
  localparam int FU_PKT_ALID_MSB    = FU_PKT_ALID_LSB + SIZE_ACTIVELIST_LOG - 1;
  localparam int FU_PKT_DEST_LSB    = FU_PKT_ALID_MSB + 1;
  localparam int FU_PKT_DEST_MSB    = FU_PKT_DEST_LSB + SIZE_PHYSICAL_LOG - 1;
  localparam int FU_PKT_FLAGS_LSB   = FU_PKT_DEST_MSB + 1;
  localparam int FU_PKT_FLAGS_MSB   = FU_PKT_FLAGS_LSB + EXECUTION_FLAGS - 1;
  localparam int FU_PKT_BRMASK_LSB  = FU_PKT_FLAGS_MSB + 1;
  localparam int FU_PKT_BRMASK_MSB  = FU_PKT_BRMASK_LSB + CHECKPOINTS - 1;
  localparam int FU_PKT_W           = FU_PKT_BRMASK_MSB + 1;

  typedef struct packed {
    logic [CHECKPOINTS-1:0]         branchMask;
    logic [EXECUTION_FLAGS-1:0]     flags;
    logic [SIZE_PHYSICAL_LOG-1:0]   destReg;
    logic [SIZE_ACTIVELIST_LOG-1:0] alId;
    logic [SIZE_DATA-1:0]           result;
  } wb_payload_t;

  function automatic wb_payload_t fu_pkt_payload(input logic [FU_PKT_W-1:0] pkt);
    wb_payload_t p;
    p.branchMask = pkt[FU_PKT_BRMASK_MSB:FU_PKT_BRMASK_LSB];
    p.flags      = pkt[FU_PKT_FLAGS_MSB:FU_PKT_FLAGS_LSB];
    p.destReg    = pkt[FU_PKT_DEST_MSB:FU_PKT_DEST_LSB];
    p.alId       = pkt[FU_PKT_ALID_MSB:FU_PKT_ALID_LSB];
    p.result     = pkt[FU_PKT_RESULT_MSB:FU_PKT_RESULT_LSB];
    return p;
  endfunction

endpackage

// File: rtl/fu1_writeback_wb_entry_filter.sv
// Branch-resolution filter for one packet: clears a correctly resolved
// checkpoint from the mask and flags a kill when a mispredict hits it.
module wb_entry_filter
  import fu1_writeback_pkg::*;
(
  input  logic [CHECKPOINTS-1:0]     i_mask,
  input  logic                       i_valid,
  input  logic                       i_ctrlVerified,
  input  logic                       i_ctrlMispredict,
  input  logic [CHECKPOINTS_LOG-1:0] i_ctrlSMTid,
  output logic [CHECKPOINTS-1:0]     o_mask,
  output logic                       o_valid,
  output logic                       o_kill
);

  always_comb begin
    o_mask = i_mask;
    o_kill = i_ctrlVerified && i_ctrlMispredict && i_mask[i_ctrlSMTid];
    if (i_ctrlVerified && !i_ctrlMispredict) begin
      o_mask[i_ctrlSMTid] = 1'b0;
    end
    o_valid = i_valid && !o_kill;
  end

endmodule

// File: rtl/fu1_writeback.sv
// FU1 writeback buffer: in-order circular holding queue between FU1 and the
// shared register-file write port, with branch squash/clear on held entries.
module fu1_writeback
  import fu1_writeback_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [FU_PKT_W-1:0]            i_inPacket,
  input  logic                           i_inValid,
  input  logic                           i_ctrlVerified,
  input  logic                           i_ctrlMispredict,
  input  logic [CHECKPOINTS_LOG-1:0]     i_ctrlSMTid,
  input  logic                           i_rfWrReady,
  output logic                           o_rfWrValid,
  output logic [SIZE_PHYSICAL_LOG-1:0]   o_rfWrAddr,
  output logic [SIZE_DATA-1:0]           o_rfWrData,
  output logic                           o_alValid,
  output logic [SIZE_ACTIVELIST_LOG-1:0] o_alId,
  output logic [EXECUTION_FLAGS-1:0]     o_alFlags,
  output logic                           o_wbStall,
  output logic                           o_overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] CNT_FULL  = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] CNT_STALL = (PTR_W+1)'(DEPTH - 1);

  wb_payload_t        r_entry [DEPTH];
  logic [DEPTH-1:0]   r_valid;
  logic [PTR_W-1:0]   r_head;
  logic [PTR_W-1:0]   r_tail;
  logic [PTR_W:0]     r_count;
  logic               r_wbStall;
  logic               r_overflow;

  wb_payload_t            w_inPayload;
  logic [CHECKPOINTS-1:0] w_inMask;
  logic                   w_inLive;
  logic                   w_inKill;
  logic [CHECKPOINTS-1:0] w_entMask [DEPTH];
  logic [DEPTH-1:0]       w_entValid;
  logic [DEPTH-1:0]       w_entKill;
  logic                   w_headOcc;
  logic                   w_push;
  logic                   w_pop;
  logic [PTR_W:0]         w_countNext;
  logic                   w_unusedFields;

  assign w_inPayload    = fu_pkt_payload(i_inPacket);
  assign w_unusedFields = ^i_inPacket[FU_PKT_IQ_MSB:FU_PKT_BRDIR_LSB];

  wb_entry_filter u_inFilter (
    .i_mask           (w_inPayload.branchMask),
    .i_valid          (i_inValid),
    .i_ctrlVerified   (i_ctrlVerified),
    .i_ctrlMispredict (i_ctrlMispredict),
    .i_ctrlSMTid      (i_ctrlSMTid),
    .o_mask           (w_inMask),
    .o_valid          (w_inLive),
    .o_kill           (w_inKill)
  );

  for (genvar g = 0; g < DEPTH; g++) begin : g_entFilter
    wb_entry_filter u_entFilter (
      .i_mask           (r_entry[g].branchMask),
      .i_valid          (r_valid[g]),
      .i_ctrlVerified   (i_ctrlVerified),
      .i_ctrlMispredict (i_ctrlMispredict),
      .i_ctrlSMTid      (i_ctrlSMTid),
      .o_mask           (w_entMask[g]),
      .o_valid          (w_entValid[g]),
      .o_kill           (w_entKill[g])
    );
  end

  // A kill on the head beats a same-cycle grant; dead heads drain silently.
  always_comb begin
    w_headOcc   = (r_count != '0);
    o_rfWrValid = w_headOcc && r_valid[r_head] && !w_entKill[r_head];
    o_alValid   = o_rfWrValid && i_rfWrReady;
    w_pop       = w_headOcc && (i_rfWrReady || !w_entValid[r_head]);
    w_push      = w_inLive && ((r_count < CNT_FULL) || w_pop);
    w_countNext = r_count + (PTR_W+1)'(w_push) - (PTR_W+1)'(w_pop);
  end

  assign o_rfWrAddr = r_entry[r_head].destReg;
  assign o_rfWrData = r_entry[r_head].result;
  assign o_alId     = r_entry[r_head].alId;
  assign o_alFlags  = r_entry[r_head].flags;
  assign o_wbStall  = r_wbStall;
  assign o_overflow = r_overflow;

  // Push writes after the per-entry refresh so a full-buffer push+pop reuses the head slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_entry[i] <= '0;
      end
      r_valid    <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_wbStall  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        r_entry[i].branchMask <= w_entMask[i];
      end
      r_valid <= w_entValid;
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + PTR_W'(1);
      end
      if (w_push) begin
        r_entry[r_tail]            <= w_inPayload;
        r_entry[r_tail].branchMask <= w_inMask;
        r_valid[r_tail]            <= 1'b1;
        r_tail                     <= r_tail + PTR_W'(1);
      end
      r_count   <= w_countNext;
      r_wbStall <= (w_countNext >= CNT_STALL);
      if (w_inLive && (r_count == CNT_FULL) && !w_pop) begin
        r_overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fu1_writeback.sv
// Directed self-checking bench for fu1_writeback (DEPTH=2).
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
module tb_fu1_writeback;
  import fu1_writeback_pkg::*;

  logic                           clk;
  logic                           rst_n;
  logic [FU_PKT_W-1:0]            inPacket;
  logic                           inValid;
  logic                           ctrlVerified;
  logic                           ctrlMispredict;
  logic [CHECKPOINTS_LOG-1:0]     ctrlSMTid;
  logic                           rfWrReady;
  logic                           rfWrValid;
  logic [SIZE_PHYSICAL_LOG-1:0]   rfWrAddr;
  logic [SIZE_DATA-1:0]           rfWrData;
  logic                           alValid;
  logic [SIZE_ACTIVELIST_LOG-1:0] alId;
  logic [EXECUTION_FLAGS-1:0]     alFlags;
  logic                           wbStall;
  logic                           overflow;

  int total = 0;
  int bad   = 0;

  fu1_writeback #(.DEPTH(2)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_inPacket       (inPacket),
    .i_inValid        (inValid),
    .i_ctrlVerified   (ctrlVerified),
    .i_ctrlMispredict (ctrlMispredict),
    .i_ctrlSMTid      (ctrlSMTid),
    .i_rfWrReady      (rfWrReady),
    .o_rfWrValid      (rfWrValid),
    .o_rfWrAddr       (rfWrAddr),
    .o_rfWrData       (rfWrData),
    .o_alValid        (alValid),
    .o_alId           (alId),
    .o_alFlags        (alFlags),
    .o_wbStall        (wbStall),
    .o_overflow       (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Dropped fields are filled with ones so a misplaced slice shows up in the outputs.
  function automatic logic [FU_PKT_W-1:0] mkPkt(input logic [3:0] mask, input logic [3:0] flags,
                                               input logic [6:0] dest, input logic [5:0] alid,
                                               input logic [31:0] res);
    return {mask, flags, dest, alid, res, {(FU_PKT_W-53){1'b1}}};
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    inValid = 1'b0; ctrlVerified = 1'b0; ctrlMispredict = 1'b0;
    ctrlSMTid = '0; rfWrReady = 1'b0; inPacket = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idleInputs();
    #1;
    if ({rfWrValid, rfWrAddr, rfWrData, alValid, alId, alFlags, wbStall, overflow} !== '0) begin
      $display("[TB] FAIL reset_outputs got=%h want=0",
               {rfWrValid, rfWrAddr, rfWrData, alValid, alId, alFlags, wbStall, overflow});
      bad++;
    end
    total++;
    cycle();
    rst_n = 1'b1;
    cycle();
    if ({rfWrValid, alValid, wbStall, overflow} !== 4'b0) begin
      $display("[TB] FAIL reset_release got=%b want=0000", {rfWrValid, alValid, wbStall, overflow});
      bad++;
    end
    total++;
  endtask

  task automatic test_pass_through();
    inPacket = mkPkt(4'b0000, 4'hA, 7'd5, 6'h11, 32'hDEAD_BEEF);
    inValid = 1'b1; rfWrReady = 1'b1;
    #1;
    if (rfWrValid !== 1'b0) begin
      $display("[TB] FAIL pt_no_bypass got=%b want=0", rfWrValid); bad++;
    end
    total++;
    cycle();
    inValid = 1'b0;
    #1;
    if ({rfWrValid, alValid, rfWrAddr, rfWrData} !== {1'b1, 1'b1, 7'd5, 32'hDEAD_BEEF}) begin
      $display("[TB] FAIL pt_write got=%b/%b/%0d/%h want=1/1/5/deadbeef",
               rfWrValid, alValid, rfWrAddr, rfWrData); bad++;
    end
    total++;
    if ({alId, alFlags, wbStall} !== {6'h11, 4'hA, 1'b1}) begin
      $display("[TB] FAIL pt_al got=%h/%h/%b want=11/a/1", alId, alFlags, wbStall); bad++;
    end
    total++;
    cycle();
    if ({rfWrValid, alValid, wbStall, dut.r_count} !== 5'b0) begin
      $display("[TB] FAIL pt_empty got=%b/%b/%b/%0d want=0/0/0/0",
               rfWrValid, alValid, wbStall, dut.r_count); bad++;
    end
    total++;
  endtask

  task automatic test_back_to_back();
    rfWrReady = 1'b1;
    inValid = 1'b1;
    inPacket = mkPkt(4'b0000, 4'h1, 7'd10, 6'h20, 32'h1000_0000);
    cycle();
    for (int i = 1; i <= 3; i++) begin
      inValid = (i < 3);
      inPacket = mkPkt(4'b0000, 4'h1, 7'(10 + i), 6'(32 + i), 32'h1000_0000 + 32'(i));
      #1;
      if ({rfWrValid, alValid, rfWrAddr, rfWrData} !==
          {1'b1, 1'b1, 7'(10 + i - 1), 32'h1000_0000 + 32'(i - 1)}) begin
        $display("[TB] FAIL b2b_%0d got=%b/%b/%0d/%h want=1/1/%0d/%h", i, rfWrValid, alValid,
                 rfWrAddr, rfWrData, 10 + i - 1, 32'h1000_0000 + 32'(i - 1)); bad++;
      end
      total++;
      cycle();
    end
    if (rfWrValid !== 1'b0 || dut.r_count !== '0) begin
      $display("[TB] FAIL b2b_drained got=%b/%0d want=0/0", rfWrValid, dut.r_count); bad++;
    end
    total++;
  endtask

  task automatic test_backpressure();
    rfWrReady = 1'b0;
    inValid = 1'b1;
    inPacket = mkPkt(4'b0000, 4'h2, 7'd1, 6'h01, 32'h0000_0111);
    cycle();
    if ({wbStall, rfWrValid, alValid} !== 3'b110) begin
      $display("[TB] FAIL bp_stall1 got=%b want=110", {wbStall, rfWrValid, alValid}); bad++;
    end
    total++;
    inPacket = mkPkt(4'b0000, 4'h3, 7'd2, 6'h02, 32'h0000_0222);
    cycle();
    inPacket = mkPkt(4'b0000, 4'h4, 7'd3, 6'h03, 32'h0000_0333);
    cycle();
    inValid = 1'b0;
    #1;
    if ({overflow, wbStall, dut.r_count} !== {1'b1, 1'b1, 2'd2}) begin
      $display("[TB] FAIL bp_overflow got=%b/%b/%0d want=1/1/2", overflow, wbStall, dut.r_count); bad++;
    end
    total++;
    rfWrReady = 1'b1;
    #1;
    if ({alValid, rfWrAddr, rfWrData} !== {1'b1, 7'd1, 32'h0000_0111}) begin
      $display("[TB] FAIL bp_first got=%b/%0d/%h want=1/1/00000111", alValid, rfWrAddr, rfWrData); bad++;
    end
    total++;
    cycle();
    if ({alValid, rfWrAddr, rfWrData, alFlags} !== {1'b1, 7'd2, 32'h0000_0222, 4'h3}) begin
      $display("[TB] FAIL bp_second got=%b/%0d/%h/%h want=1/2/00000222/3",
               alValid, rfWrAddr, rfWrData, alFlags); bad++;
    end
    total++;
    cycle();
    if ({rfWrValid, overflow, wbStall} !== 3'b010) begin
      $display("[TB] FAIL bp_third_absent got=%b want=010", {rfWrValid, overflow, wbStall}); bad++;
    end
    total++;
  endtask

  task automatic test_squash();
    rfWrReady = 1'b0;
    inValid = 1'b1;
    inPacket = mkPkt(4'b0010, 4'h5, 7'd21, 6'h15, 32'h0000_0021);
    cycle();
    inPacket = mkPkt(4'b0000, 4'h6, 7'd22, 6'h16, 32'h0000_0022);
    cycle();
    inValid = 1'b0;
    rfWrReady = 1'b1;
    ctrlVerified = 1'b1; ctrlMispredict = 1'b1; ctrlSMTid = 2'd1;
    #1;
    if ({rfWrValid, alValid} !== 2'b00) begin
      $display("[TB] FAIL sq_kill_wins got=%b want=00", {rfWrValid, alValid}); bad++;
    end
    total++;
    cycle();
    ctrlVerified = 1'b0; ctrlMispredict = 1'b0; ctrlSMTid = '0;
    #1;
    if ({alValid, rfWrAddr, rfWrData} !== {1'b1, 7'd22, 32'h0000_0022}) begin
      $display("[TB] FAIL sq_survivor got=%b/%0d/%h want=1/22/00000022", alValid, rfWrAddr, rfWrData); bad++;
    end
    total++;
    cycle();
    if (rfWrValid !== 1'b0 || dut.r_count !== '0) begin
      $display("[TB] FAIL sq_empty got=%b/%0d want=0/0", rfWrValid, dut.r_count); bad++;
    end
    total++;
  endtask

  task automatic test_clear_then_mispredict();
    rfWrReady = 1'b0;
    inValid = 1'b1;
    inPacket = mkPkt(4'b0100, 4'h7, 7'd33, 6'h21, 32'h0000_0033);
    cycle();
    inPacket = mkPkt(4'b0100, 4'h8, 7'd34, 6'h22, 32'h0000_0034);
    ctrlVerified = 1'b1; ctrlMispredict = 1'b0; ctrlSMTid = 2'd2;
    cycle();
    inValid = 1'b0;
    ctrlMispredict = 1'b1;
    rfWrReady = 1'b1;
    #1;
    if ({rfWrValid, alValid, rfWrAddr} !== {1'b1, 1'b1, 7'd33}) begin
      $display("[TB] FAIL cm_held got=%b/%b/%0d want=1/1/33", rfWrValid, alValid, rfWrAddr); bad++;
    end
    total++;
    cycle();
    ctrlVerified = 1'b0; ctrlMispredict = 1'b0;
    #1;
    if ({rfWrValid, rfWrAddr, rfWrData} !== {1'b1, 7'd34, 32'h0000_0034}) begin
      $display("[TB] FAIL cm_incoming got=%b/%0d/%h want=1/34/00000034", rfWrValid, rfWrAddr, rfWrData); bad++;
    end
    total++;
    cycle();
    // Incoming packet killed on arrival into an empty buffer.
    inValid = 1'b1;
    inPacket = mkPkt(4'b1000, 4'h9, 7'd35, 6'h23, 32'h0000_0035);
    ctrlVerified = 1'b1; ctrlMispredict = 1'b1; ctrlSMTid = 2'd3;
    cycle();
    inValid = 1'b0; ctrlVerified = 1'b0; ctrlMispredict = 1'b0; ctrlSMTid = '0;
    #1;
    if ({rfWrValid, dut.r_count, wbStall} !== 4'b0) begin
      $display("[TB] FAIL cm_in_killed got=%b/%0d/%b want=0/0/0", rfWrValid, dut.r_count, wbStall); bad++;
    end
    total++;
  endtask

  task automatic test_simultaneous();
    rfWrReady = 1'b0;
    inValid = 1'b1;
    inPacket = mkPkt(4'b0000, 4'hB, 7'd41, 6'h29, 32'h0000_0041);
    cycle();
    rfWrReady = 1'b1;
    inPacket = mkPkt(4'b0001, 4'hC, 7'd42, 6'h2A, 32'h0000_0042);
    ctrlVerified = 1'b1; ctrlMispredict = 1'b1; ctrlSMTid = 2'd0;
    #1;
    if ({rfWrValid, alValid, rfWrAddr} !== {1'b1, 1'b1, 7'd41}) begin
      $display("[TB] FAIL sim_head got=%b/%b/%0d want=1/1/41", rfWrValid, alValid, rfWrAddr); bad++;
    end
    total++;
    cycle();
    inValid = 1'b0; ctrlVerified = 1'b0; ctrlMispredict = 1'b0;
    #1;
    if ({rfWrValid, alValid, dut.r_count} !== 4'b0) begin
      $display("[TB] FAIL sim_empty got=%b/%b/%0d want=0/0/0", rfWrValid, alValid, dut.r_count); bad++;
    end
    total++;
  endtask

  task automatic test_reset_mid();
    rfWrReady = 1'b0;
    inValid = 1'b1;
    inPacket = mkPkt(4'b0000, 4'hD, 7'd51, 6'h31, 32'h0000_0051);
    cycle();
    inPacket = mkPkt(4'b0000, 4'hE, 7'd52, 6'h32, 32'h0000_0052);
    cycle();
    inPacket = mkPkt(4'b0000, 4'hF, 7'd53, 6'h33, 32'h0000_0053);
    cycle();
    idleInputs();
    #2;
    rfWrReady = 1'b1;
    rst_n = 1'b0;
    #1;
    if ({rfWrValid, rfWrAddr, rfWrData, alValid, alId, alFlags, wbStall, overflow, dut.r_count} !== '0) begin
      $display("[TB] FAIL rm_in_reset got=%b/%0d/%h/%b/%h/%h/%b/%b/%0d want=all 0", rfWrValid, rfWrAddr,
               rfWrData, alValid, alId, alFlags, wbStall, overflow, dut.r_count); bad++;
    end
    total++;
    cycle();
    rst_n = 1'b1;
    inValid = 1'b1;
    inPacket = mkPkt(4'b0000, 4'h6, 7'd60, 6'h3C, 32'hCAFE_0060);
    cycle();
    inValid = 1'b0;
    #1;
    if ({rfWrValid, alValid, rfWrAddr, rfWrData, alId, overflow} !==
        {1'b1, 1'b1, 7'd60, 32'hCAFE_0060, 6'h3C, 1'b0}) begin
      $display("[TB] FAIL rm_after got=%b/%b/%0d/%h/%h/%b want=1/1/60/cafe0060/3c/0",
               rfWrValid, alValid, rfWrAddr, rfWrData, alId, overflow); bad++;
    end
    total++;
    cycle();
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_back_to_back();
    test_backpressure();
    test_squash();
    test_clear_then_mispredict();
    test_simultaneous();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
